riscv_multicycle_controller: RTL and testbench
==============================================

// Module: riscv_multicycle_controller
// PURPOSE
//  Multicycle RV32I control unit: a Moore FSM plus combinational ALU/imm decode.
//  Sequences fetch/decode/execute/mem/writeback over a shared memory.
//  Stalls on a memory ready handshake; resolves all six branch types from ALU flags.
//  Sits between the instruction register and the multicycle datapath.
// PARAMETERS
//  ALUCTRL_W    4  alucontrol width; 3 = add/sub/and/or/slt only, 4 = full set below
//  BRANCH_FULL  1  1: beq/bne/blt/bge/bltu/bgeu; 0: beq only (funct3 ignored)
// PORTS
//  clk         in   1  clock, rising edge
//  reset_n     in   1  asynchronous active-low reset
//  op          in   7  instr[6:0]
//  funct3      in   3  instr[14:12]
//  f7b5        in   1  instr[30]
//  zero,lt,ltu in   1  ALU flags: result==0, signed a<b, unsigned a<b
//  mem_ready   in   1  memory completes the access this cycle
//  mem_req     out  1  memory access request (fetch/read/write)
//  memwrite    out  1  store strobe, valid with mem_req
//  adrsrc      out  1  0 = PC, 1 = ALUOut
//  irwrite     out  1  latch instruction register
//  pcwrite     out  1  = pcupdate | (branch & taken)
//  regwrite    out  1  register-file write enable
//  resultsrc   out  2  00 ALUOut, 01 Data, 10 ALUResult
//  alusrca     out  2  00 PC, 01 OldPC, 10 rd1, 11 zero
//  alusrcb     out  2  00 rd2, 01 imm, 10 const 4
//  immsrc      out  3  000 I, 001 S, 010 B, 011 J, 100 U (from op, comb.)
//  alucontrol  out  ALUCTRL_W  ALU op code
//  illegal     out  1  trap flag (macro only; else tied 0)
//  state_o     out  4  current state, debug
// BEHAVIOUR
//  States (enc): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXR6 EXI7 ALUWB8 BR9 JAL10 LUI11 TRAP12
//  reset_n=0: state<=FETCH asynchronously; all strobes (mem_req memwrite irwrite pcwrite
//   regwrite) and all mux selects 0, illegal=0; applies mid-access, pending access dropped.
//  FETCH: mem_req=1 adrsrc=0 A=PC B=4 add resultsrc=10; irwrite and pcupdate only in the
//   mem_ready=1 cycle -> DECODE; else hold (strobes 0).
//  DECODE: A=OldPC B=imm add (branch target). Next by op: 0000011/0100011->MEMADR,
//   0110011->EXR, 0010011->EXI, 1100011->BR, 1101111->JAL, 0110111->LUI, other->illegal path.
//  MEMADR: A=rd1 B=imm add; op[5]=0->MEMRD, 1->MEMWR.
//  MEMRD: mem_req=1 adrsrc=1; wait mem_ready -> MEMWB. MEMWB: resultsrc=01 regwrite -> FETCH.
//  MEMWR: mem_req=1 memwrite=1 adrsrc=1; wait mem_ready -> FETCH. Ends on mem_ready cycle.
//  EXR: A=rd1 B=rd2 aluop=10 -> ALUWB. EXI: A=rd1 B=imm aluop=10 -> ALUWB.
//  ALUWB: resultsrc=00 regwrite -> FETCH. LUI: A=zero B=imm add -> ALUWB.
//  BR: A=rd1 B=rd2 sub resultsrc=00; taken: 000 zero, 001 !zero, 100 lt, 101 !lt,
//   110 ltu, 111 !ltu; 010/011 never taken. BRANCH_FULL=0: taken=zero. -> FETCH.
//  JAL: A=OldPC B=4 add resultsrc=00 pcupdate=1 -> ALUWB.
//  ALU decode: aluop 00 add, 01 sub, 10 by funct3: 000 add (sub if f7b5&op[5]), 001 sll,
//   010 slt, 011 sltu, 100 xor, 101 srl/sra(f7b5), 110 or, 111 and.
//  Codes W=4: add0 sub1 and2 or3 xor4 slt5 sltu6 sll7 srl8 sra9. W=3: add0 sub1 and2
//   or3 slt5; any other op -> add, treated as illegal.
//  Zero-wait cycles: lw 5, sw 4, R/I/lui 4, branch 3, jal 4. Each mem_ready=0 adds 1.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: illegal op/funct -> TRAP; illegal=1, all strobes 0,
//   held until reset. Undefined: illegal -> FETCH (nop), illegal tied 0.
// TESTING
//  Reset mid-MEMRD (mem_ready=0) -> state_o=0 same cycle, mem_req=0 while reset_n=0.
//  add (op 0110011 f3 000 f7b5 0), mem_ready=1 -> states 0,1,6,8,0; regwrite only in 8, alucontrol=0.
//  lw, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, regwrite once in MEMWB.
//  bne f3 001 zero=0 -> pcwrite=1 in BR; zero=1 -> pcwrite=0; BRANCH_FULL=0 -> pcwrite=0 on zero=0.
//  sra f3 101 f7b5 1, ALUCTRL_W=4 -> alucontrol=9; ALUCTRL_W=3 -> illegal path.
//  op 1111111 with CTRL_ILLEGAL_TRAP_EN -> state_o=12, illegal=1 sticky; without -> FETCH.

Source files
------------

// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller
//   Multicycle RV32I control unit. A Moore FSM sequences
//   fetch/decode/execute/memory/writeback over a shared memory, and it stalls
//   on the memory ready handshake. Combinational logic decodes the immediate
//   format and the ALU operation and resolves branches from the ALU flags.
//
// Parameters
//   ALUCTRL_W    alucontrol width: 4 = full code set, 3 = add/sub/and/or/slt only
//   BRANCH_FULL  1: all six branch conditions, 0: beq only (funct3 ignored)
//
// Optional feature
//   CTRL_ILLEGAL_TRAP_EN  defined: an illegal op or funct sends the FSM to TRAP.
//                         TRAP holds illegal=1 with all strobes low until reset.
//                         undefined: an illegal instruction is retired as a nop
//                         (back to FETCH), and illegal is tied 0.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   op, funct3, f7b5        instruction fields instr[6:0], instr[14:12], instr[30]
//   zero, lt, ltu           ALU flags: result==0, signed a<b, unsigned a<b
//   mem_ready               memory completes the pending access this cycle
//   mem_req, memwrite       memory request and store strobe
//   adrsrc                  memory address select (0 PC, 1 ALUOut)
//   irwrite, pcwrite        instruction register and PC write enables
//   regwrite                register-file write enable
//   resultsrc               00 ALUOut, 01 Data, 10 ALUResult
//   alusrca, alusrcb        A: 00 PC, 01 OldPC, 10 rd1, 11 zero / B: 00 rd2, 01 imm, 10 const 4
//   immsrc                  000 I, 001 S, 010 B, 011 J, 100 U
//   alucontrol              ALU operation code
//   illegal                 trap flag
//   state_o                 current FSM state (debug)
module riscv_multicycle_controller #(
    parameter int ALUCTRL_W   = 4,
    parameter int BRANCH_FULL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 f7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 memwrite,
    output logic                 adrsrc,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic [1:0]           resultsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [2:0]           immsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI   = 4'd7,
        S_ALUWB  = 4'd8,  S_BR     = 4'd9,  S_JAL    = 4'd10, S_LUI   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    // Full-width ALU code for an aluop; only R-type (op[5]=1) turns funct3=000 into sub.
    function automatic logic [3:0] alu_code(input logic [1:0] aluop, input logic [2:0] f3,
                                            input logic b5, input logic op5);
        logic [3:0] code;
        code = ALU_ADD;
        if (aluop == 2'b01) begin
            code = ALU_SUB;
        end else if (aluop == 2'b10) begin
            case (f3)
                3'b000:  code = (b5 && op5) ? ALU_SUB : ALU_ADD;
                3'b001:  code = ALU_SLL;
                3'b010:  code = ALU_SLT;
                3'b011:  code = ALU_SLTU;
                3'b100:  code = ALU_XOR;
                3'b101:  code = b5 ? ALU_SRA : ALU_SRL;
                3'b110:  code = ALU_OR;
                default: code = ALU_AND;
            endcase
        end
        return code;
    endfunction

    // The narrow ALU only implements the first five operations.
    function automatic logic code_legal(input logic [3:0] code);
        if (ALUCTRL_W >= 4) return 1'b1;
        return code inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
    endfunction

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcupdate, branch, taken, funct_illegal;
    logic [3:0] alu_full, alu_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Illegal funct is judged at DECODE so the FSM never enters EXR/EXI with it.
    always_comb begin
        funct_illegal = ((op == OP_R) || (op == OP_I)) &&
                        !code_legal(alu_code(2'b10, funct3, f7b5, op[5]));
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        memwrite  = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (mem_ready) begin
                    irwrite  = 1'b1;
                    pcupdate = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = funct_illegal ? ILL_NEXT : S_EXR;
                    OP_I:              state_d = funct_illegal ? ILL_NEXT : S_EXI;
                    OP_BR:             state_d = S_BR;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = ILL_NEXT;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adrsrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                adrsrc   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BR: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
                state_d = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase
        // The state register is already FETCH during reset, but FETCH drives
        // mem_req; everything is forced quiet until reset_n rises.
        if (!reset_n) begin
            mem_req   = 1'b0;
            memwrite  = 1'b0;
            adrsrc    = 1'b0;
            irwrite   = 1'b0;
            regwrite  = 1'b0;
            resultsrc = 2'b00;
            alusrca   = 2'b00;
            alusrcb   = 2'b00;
            aluop     = 2'b00;
            pcupdate  = 1'b0;
            branch    = 1'b0;
        end
    end

    always_comb begin
        if (BRANCH_FULL != 0) begin
            case (funct3)
                3'b000:  taken = zero;
                3'b001:  taken = !zero;
                3'b100:  taken = lt;
                3'b101:  taken = !lt;
                3'b110:  taken = ltu;
                3'b111:  taken = !ltu;
                default: taken = 1'b0;
            endcase
        end else begin
            taken = zero;
        end
    end

    always_comb begin
        immsrc = 3'b000;
        if (reset_n) begin
            case (op)
                OP_STORE:         immsrc = 3'b001;
                OP_BR:            immsrc = 3'b010;
                OP_JAL:           immsrc = 3'b011;
                OP_LUI, OP_AUIPC: immsrc = 3'b100;
                OP_JALR:          immsrc = 3'b000;
                default:          immsrc = 3'b000;
            endcase
        end
    end

    always_comb begin
        alu_full = alu_code(aluop, funct3, f7b5, op[5]);
        alu_sel  = code_legal(alu_full) ? alu_full : ALU_ADD;
    end

    assign alucontrol = alu_sel[ALUCTRL_W-1:0];
    assign pcwrite    = pcupdate | (branch & taken);
    assign state_o    = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = reset_n & (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
module tb_riscv_multicycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, f7b5, zero, lt, ltu, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;

    // default instance: ALUCTRL_W=4, BRANCH_FULL=1
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc;
    logic [3:0] alucontrol, state;

    // narrow ALU instance: ALUCTRL_W=3
    logic       w3_mem_req, w3_memwrite, w3_adrsrc, w3_irwrite, w3_pcwrite, w3_regwrite, w3_illegal;
    logic [1:0] w3_resultsrc, w3_alusrca, w3_alusrcb;
    logic [2:0] w3_immsrc, w3_alucontrol;
    logic [3:0] w3_state;

    // beq-only instance: BRANCH_FULL=0
    logic       bf_mem_req, bf_memwrite, bf_adrsrc, bf_irwrite, bf_pcwrite, bf_regwrite, bf_illegal;
    logic [1:0] bf_resultsrc, bf_alusrca, bf_alusrcb;
    logic [2:0] bf_immsrc;
    logic [3:0] bf_alucontrol, bf_state;

    riscv_multicycle_controller #(.ALUCTRL_W(4), .BRANCH_FULL(1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .f7b5(f7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
        .pcwrite(pcwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal),
        .state_o(state));

    riscv_multicycle_controller #(.ALUCTRL_W(3), .BRANCH_FULL(1)) dut_w3 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .f7b5(f7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(w3_mem_req), .memwrite(w3_memwrite), .adrsrc(w3_adrsrc), .irwrite(w3_irwrite),
        .pcwrite(w3_pcwrite), .regwrite(w3_regwrite), .resultsrc(w3_resultsrc),
        .alusrca(w3_alusrca), .alusrcb(w3_alusrcb), .immsrc(w3_immsrc),
        .alucontrol(w3_alucontrol), .illegal(w3_illegal), .state_o(w3_state));

    riscv_multicycle_controller #(.ALUCTRL_W(4), .BRANCH_FULL(0)) dut_bf (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .f7b5(f7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(bf_mem_req), .memwrite(bf_memwrite), .adrsrc(bf_adrsrc), .irwrite(bf_irwrite),
        .pcwrite(bf_pcwrite), .regwrite(bf_regwrite), .resultsrc(bf_resultsrc),
        .alusrca(bf_alusrca), .alusrcb(bf_alusrcb), .immsrc(bf_immsrc),
        .alucontrol(bf_alucontrol), .illegal(bf_illegal), .state_o(bf_state));

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BAD = 7'b1111111;

    // strb = {mem_req, memwrite, irwrite, pcwrite, regwrite}
    // sel  = {adrsrc, resultsrc[1:0], alusrca[1:0], alusrcb[1:0]}
    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic [2:0] f3;
        logic       b5, z, lt, ltu, rdy;
        logic [3:0] st;
        logic [4:0] strb;
        logic [6:0] sel;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic vec(input logic rst_n, input logic [6:0] o, input logic [2:0] f3,
                       input logic b5, input logic z, input logic l, input logic lu,
                       input logic rdy, input logic [3:0] st, input logic [4:0] strb,
                       input logic [6:0] sel, input logic [2:0] imm, input logic [3:0] alu,
                       input logic ill);
        vec_t v;
        v.rst_n = rst_n; v.op = o; v.f3 = f3; v.b5 = b5; v.z = z; v.lt = l; v.ltu = lu;
        v.rdy = rdy; v.st = st; v.strb = strb; v.sel = sel; v.imm = imm; v.alu = alu;
        v.ill = ill;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic [6:0] o, input logic [2:0] f3,
                         input logic b5, input logic z, input logic l, input logic lu,
                         input logic rdy);
        reset_n = rst_n; op = o; funct3 = f3; f7b5 = b5; zero = z; lt = l; ltu = lu;
        mem_ready = rdy;
    endtask

    initial begin
        drive(1'b0, R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        //   rst op   f3      b5 z  lt ltu rdy st     strb      sel          imm    alu  ill
        // add
        vec(0, R,   3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b00000, 7'b0000000, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 0, 0, 0, 0, 1, 4'd6,  5'b00000, 7'b0001000, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 0, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b000, 4'd0, 0);
        // lw: fetch stalls once, MEMRD stalls twice
        vec(1, LD,  3'b010, 0, 0, 0, 0, 0, 4'd0,  5'b10000, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 0, 4'd2,  5'b00000, 7'b0001001, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 0, 4'd3,  5'b10000, 7'b1000000, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 0, 4'd3,  5'b10000, 7'b1000000, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 1, 4'd3,  5'b10000, 7'b1000000, 3'b000, 4'd0, 0);
        vec(1, LD,  3'b010, 0, 0, 0, 0, 1, 4'd4,  5'b00001, 7'b0010000, 3'b000, 4'd0, 0);
        // sw with one wait cycle
        vec(1, ST,  3'b010, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b001, 4'd0, 0);
        vec(1, ST,  3'b010, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b001, 4'd0, 0);
        vec(1, ST,  3'b010, 0, 0, 0, 0, 0, 4'd2,  5'b00000, 7'b0001001, 3'b001, 4'd0, 0);
        vec(1, ST,  3'b010, 0, 0, 0, 0, 0, 4'd5,  5'b11000, 7'b1000000, 3'b001, 4'd0, 0);
        vec(1, ST,  3'b010, 0, 0, 0, 0, 1, 4'd5,  5'b11000, 7'b1000000, 3'b001, 4'd0, 0);
        // bne taken / not taken
        vec(1, BR,  3'b001, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b001, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b001, 0, 0, 0, 0, 1, 4'd9,  5'b00010, 7'b0001000, 3'b010, 4'd1, 0);
        vec(1, BR,  3'b001, 0, 1, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b001, 0, 1, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b001, 0, 1, 0, 0, 1, 4'd9,  5'b00000, 7'b0001000, 3'b010, 4'd1, 0);
        // blt taken, bgeu not taken
        vec(1, BR,  3'b100, 0, 0, 1, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b100, 0, 0, 1, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b100, 0, 0, 1, 0, 1, 4'd9,  5'b00010, 7'b0001000, 3'b010, 4'd1, 0);
        vec(1, BR,  3'b111, 0, 0, 0, 1, 1, 4'd0,  5'b10110, 7'b0100010, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b111, 0, 0, 0, 1, 1, 4'd1,  5'b00000, 7'b0000101, 3'b010, 4'd0, 0);
        vec(1, BR,  3'b111, 0, 0, 0, 1, 1, 4'd9,  5'b00000, 7'b0001000, 3'b010, 4'd1, 0);
        // jal
        vec(1, JAL, 3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b011, 4'd0, 0);
        vec(1, JAL, 3'b000, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b011, 4'd0, 0);
        vec(1, JAL, 3'b000, 0, 0, 0, 0, 1, 4'd10, 5'b00010, 7'b0000110, 3'b011, 4'd0, 0);
        vec(1, JAL, 3'b000, 0, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b011, 4'd0, 0);
        // lui
        vec(1, LUI, 3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b100, 4'd0, 0);
        vec(1, LUI, 3'b000, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b100, 4'd0, 0);
        vec(1, LUI, 3'b000, 0, 0, 0, 0, 1, 4'd11, 5'b00000, 7'b0001101, 3'b100, 4'd0, 0);
        vec(1, LUI, 3'b000, 0, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b100, 4'd0, 0);
        // sra
        vec(1, R,   3'b101, 1, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, R,   3'b101, 1, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
        vec(1, R,   3'b101, 1, 0, 0, 0, 1, 4'd6,  5'b00000, 7'b0001000, 3'b000, 4'd9, 0);
        vec(1, R,   3'b101, 1, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b000, 4'd0, 0);
        // addi with instr[30]=1 stays add
        vec(1, OPI, 3'b000, 1, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, OPI, 3'b000, 1, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
        vec(1, OPI, 3'b000, 1, 0, 0, 0, 1, 4'd7,  5'b00000, 7'b0001001, 3'b000, 4'd0, 0);
        vec(1, OPI, 3'b000, 1, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b000, 4'd0, 0);
        // sub
        vec(1, R,   3'b000, 1, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 1, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
        vec(1, R,   3'b000, 1, 0, 0, 0, 1, 4'd6,  5'b00000, 7'b0001000, 3'b000, 4'd1, 0);
        vec(1, R,   3'b000, 1, 0, 0, 0, 1, 4'd8,  5'b00001, 7'b0000000, 3'b000, 4'd0, 0);
        // unknown opcode
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd12, 5'b00000, 7'b0000000, 3'b000, 4'd0, 1);
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd12, 5'b00000, 7'b0000000, 3'b000, 4'd0, 1);
`else
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b10110, 7'b0100010, 3'b000, 4'd0, 0);
        vec(1, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd1,  5'b00000, 7'b0000101, 3'b000, 4'd0, 0);
`endif
        vec(0, BAD, 3'b000, 0, 0, 0, 0, 1, 4'd0,  5'b00000, 7'b0000000, 3'b000, 4'd0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst_n, vq[i].op, vq[i].f3, vq[i].b5, vq[i].z, vq[i].lt, vq[i].ltu,
                  vq[i].rdy);
            #1;
            chk($sformatf("v%0d state", i),  16'(state), 16'(vq[i].st));
            chk($sformatf("v%0d strobes", i),
                16'({mem_req, memwrite, irwrite, pcwrite, regwrite}), 16'(vq[i].strb));
            chk($sformatf("v%0d selects", i),
                16'({adrsrc, resultsrc, alusrca, alusrcb}), 16'(vq[i].sel));
            chk($sformatf("v%0d immsrc", i), 16'(immsrc), 16'(vq[i].imm));
            chk($sformatf("v%0d alucontrol", i), 16'(alucontrol), 16'(vq[i].alu));
            chk($sformatf("v%0d illegal", i), 16'(illegal), 16'(vq[i].ill));
        end

        // Reset asserted mid-MEMRD, between clock edges.
        @(negedge clk); drive(1, LD, 3'b010, 0, 0, 0, 0, 1);   // FETCH
        @(negedge clk);                                         // DECODE
        @(negedge clk); mem_ready = 1'b0;                       // MEMADR
        @(negedge clk); #1;                                     // MEMRD, waiting
        chk("midrd state before reset", 16'(state), 16'd3);
        chk("midrd mem_req before reset", 16'(mem_req), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrd state async", 16'(state), 16'd0);
        chk("midrd mem_req async", 16'(mem_req), 16'd0);
        chk("midrd adrsrc async", 16'(adrsrc), 16'd0);
        @(negedge clk); #1;
        chk("midrd state held", 16'(state), 16'd0);
        chk("midrd mem_req held", 16'(mem_req), 16'd0);
        @(negedge clk); drive(1, R, 3'b000, 0, 0, 0, 0, 1); #1;
        chk("after reset fetch irwrite", 16'(irwrite), 16'd1);
        chk("after reset fetch mem_req", 16'(mem_req), 16'd1);

        // beq-only variant: bne with zero=0 not taken, zero=1 taken.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); drive(1, BR, 3'b001, 0, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("bf bne z0 state", 16'(bf_state), 16'd9);
        chk("bf bne z0 pcwrite", 16'(bf_pcwrite), 16'd0);
        chk("full bne z0 pcwrite", 16'(pcwrite), 16'd1);
        @(negedge clk); zero = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("bf bne z1 pcwrite", 16'(bf_pcwrite), 16'd1);
        chk("full bne z1 pcwrite", 16'(pcwrite), 16'd0);

        // narrow ALU: sra is illegal, slt is code 5.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); drive(1, R, 3'b101, 1, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("w4 sra state", 16'(state), 16'd6);
        chk("w4 sra alucontrol", 16'(alucontrol), 16'd9);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("w3 sra state", 16'(w3_state), 16'd12);
        chk("w3 sra illegal", 16'(w3_illegal), 16'd1);
`else
        chk("w3 sra state", 16'(w3_state), 16'd0);
        chk("w3 sra illegal", 16'(w3_illegal), 16'd0);
`endif
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); drive(1, R, 3'b010, 0, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("w3 slt state", 16'(w3_state), 16'd6);
        chk("w3 slt alucontrol", 16'(w3_alucontrol), 16'd5);
        chk("w4 slt alucontrol", 16'(alucontrol), 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
